// File: rtl/armaria_pkg.sv
// rtl/armaria_pkg.sv - shared load-path codes, FSM state type and decode helpers
//
// Contents:
//   SIZE_*          request size codes (reserved code 3 behaves as a word)
//   SE_*            extension codes consumed by the sign-extension stage
//   load_state_t    load unit FSM states
//   load_is_split   does an access of this size/offset straddle two words
//   load_se_code    extension code for a size/signedness pair
package armaria_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0] SE_PASS  = 3'd0;
    localparam logic [2:0] SE_SHALF = 3'd1;
    localparam logic [2:0] SE_SBYTE = 3'd2;
    localparam logic [2:0] SE_ZHALF = 3'd3;
    localparam logic [2:0] SE_ZBYTE = 3'd4;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_FIRST  = 2'd1,
        LD_SECOND = 2'd2,
        LD_DONE   = 2'd3
    } load_state_t;

    function automatic logic load_is_split(input logic [1:0] size, input logic [1:0] offset);
        logic split;
        case (size)
            SIZE_BYTE: split = 1'b0;
            SIZE_HALF: split = (offset == 2'd3);
            default:   split = (offset != 2'd0);
        endcase
        return split;
    endfunction

    function automatic logic [2:0] load_se_code(input logic [1:0] size, input logic sign);
        logic [2:0] code;
        case (size)
            SIZE_BYTE: code = sign ? SE_SBYTE : SE_ZBYTE;
            SIZE_HALF: code = sign ? SE_SHALF : SE_ZHALF;
            default:   code = SE_PASS;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/load_lane_merge.sv
// rtl/load_lane_merge.sv - combinational right-justification of a load from one or two words
//
// Ports:
//   w1      in   32  word holding the addressed byte
//   w2      in   32  following word (only consulted when the access is split)
//   offset  in   2   byte offset of the address within w1
//   size    in   2   size code; sub-word results have upper bits zeroed
//   data    out  32  right-justified result
module load_lane_merge
    import armaria_pkg::*;
(
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    output logic [31:0] data
);

    // Treat {w2, w1} as one little-endian byte stream and shift the addressed
    // byte to lane 0. A split halfword or word then picks up w2's low bytes.
    logic [31:0] shifted;
    logic        unused_w2_top;

    assign unused_w2_top = ^w2[31:24];

    always_comb begin
        shifted = w1;
        case (offset)
            2'd0: shifted = w1;
            2'd1: shifted = {w2[7:0],  w1[31:8]};
            2'd2: shifted = {w2[15:0], w1[31:16]};
            2'd3: shifted = {w2[23:0], w1[31:24]};
            default: shifted = w1;
        endcase
    end

    always_comb begin
        data = shifted;
        case (size)
            SIZE_BYTE: data = {24'h0, shifted[7:0]};
            SIZE_HALF: data = {16'h0, shifted[15:0]};
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - multi-cycle load unit: one or two word reads, right-justified result
//
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   req_valid/req_ready       request handshake; req_addr, req_size, req_signed describe it
//   mem_req/mem_addr          word read strobe and word address, held until mem_ready
//   mem_ready/mem_rdata       read completion and little-endian read word
//   out_valid/out_ready       result handshake; out_data, out_se_ctrl stable while valid
module load_aligner
    import armaria_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_se_ctrl
);

    load_state_t state;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        split_q;
    logic [2:0]  se_q;
    logic [31:0] w1_q;

    logic [31:0] merge_w1;
    logic [31:0] merged;

    // In FIRST the word is still on the bus; in SECOND the first word comes
    // from its capture register and the bus carries the second word.
    assign merge_w1 = (state == LD_FIRST) ? mem_rdata : w1_q;

    load_lane_merge u_merge (
        .w1     (merge_w1),
        .w2     (mem_rdata),
        .offset (offset_q),
        .size   (size_q),
        .data   (merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LD_IDLE;
            req_ready   <= 1'b1;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_se_ctrl <= SE_PASS;
            offset_q    <= 2'd0;
            size_q      <= SIZE_BYTE;
            split_q     <= 1'b0;
            se_q        <= SE_PASS;
            w1_q        <= 32'h0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (req_valid && req_ready) begin
                        offset_q  <= req_addr[1:0];
                        size_q    <= req_size;
                        split_q   <= load_is_split(req_size, req_addr[1:0]);
                        se_q      <= load_se_code(req_size, req_signed);
                        mem_addr  <= req_addr[ADDR_WIDTH-1:2];
                        mem_req   <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= LD_FIRST;
                    end
                end
                LD_FIRST: begin
                    if (mem_ready) begin
                        w1_q <= mem_rdata;
                        if (split_q) begin
                            // Natural width overflow wraps the top word back to 0.
                            mem_addr <= mem_addr + 1'b1;
                            state    <= LD_SECOND;
                        end else begin
                            mem_req     <= 1'b0;
                            out_data    <= merged;
                            out_se_ctrl <= se_q;
                            out_valid   <= 1'b1;
                            state       <= LD_DONE;
                        end
                    end
                end
                LD_SECOND: begin
                    if (mem_ready) begin
                        mem_req     <= 1'b0;
                        out_data    <= merged;
                        out_se_ctrl <= se_q;
                        out_valid   <= 1'b1;
                        state       <= LD_DONE;
                    end
                end
                LD_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= LD_IDLE;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_aligner.sv
// tb/tb_load_aligner.sv - self-checking bench for load_aligner against a byte-level memory model
module tb_load_aligner;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_se_ctrl;

    int checks = 0;
    int errors = 0;

    load_aligner #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_se_ctrl (out_se_ctrl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_words [logic [29:0]];

    function automatic logic [31:0] rd(input logic [29:0] wa);
        if (mem_words.exists(wa)) return mem_words[wa];
        return 32'h0;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Gather the load one byte address at a time from the memory model.
    function automatic logic [31:0] model_data(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r;
        logic [31:0] ba;
        logic [31:0] w;
        r = 32'h0;
        for (int i = 0; i < size_bytes(sz); i++) begin
            ba = a + 32'(i);
            w  = rd(ba[31:2]);
            r  = r | (((w >> (8 * ba[1:0])) & 32'hFF) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [2:0] model_se(input logic [1:0] sz, input logic sgn);
        if (sz == 2'd0) return sgn ? 3'd2 : 3'd4;
        if (sz == 2'd1) return sgn ? 3'd1 : 3'd3;
        return 3'd0;
    endfunction

    // ---------------- memory responder ----------------
    int          stall_left = 0;
    int          wait_cfg   = 0;
    logic [29:0] acc_log [$];

    always @(posedge clock) begin
        if (reset_n && mem_req && mem_ready) begin
            acc_log.push_back(mem_addr);
            stall_left = wait_cfg;
        end
    end

    always @(negedge clock) begin
        if (mem_req && reset_n) begin
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = rd(mem_addr);
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    // ---------------- continuous compare ----------------
    logic [31:0] exp_data = 32'h0;
    logic [2:0]  exp_se   = 3'd0;
    logic        prev_req = 1'b0, prev_ready = 1'b0, prev_ov = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [31:0] prev_data = 32'h0;
    logic [2:0]  prev_se = 3'd0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid) begin
                check("out_data", out_data, exp_data);
                check("out_se_ctrl", 32'(out_se_ctrl), 32'(exp_se));
                if (prev_ov) begin
                    check("out_data_stable", out_data, prev_data);
                    check("out_se_stable", 32'(out_se_ctrl), 32'(prev_se));
                end
            end
            if (mem_req || out_valid)
                check("req_ready_busy", 32'(req_ready), 32'd0);
            if (mem_req && prev_req && !prev_ready)
                check("mem_addr_held", 32'(mem_addr), 32'(prev_addr));
        end
        prev_req  = mem_req && reset_n;
        prev_ready = mem_ready;
        prev_addr = mem_addr;
        prev_ov   = out_valid && reset_n;
        prev_data = out_data;
        prev_se   = out_se_ctrl;
    end

    // ---------------- directed load ----------------
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                           input int waitc, input int bp,
                           input logic [31:0] lit_data, input logic [2:0] lit_se,
                           input int lit_cycles);
        int          cyc;
        int          nacc;
        logic [31:0] last;
        exp_data = model_data(a, sz);
        exp_se   = model_se(sz, sgn);
        check("model_pin_data", exp_data, lit_data);
        check("model_pin_se", 32'(exp_se), 32'(lit_se));
        last = a + 32'(size_bytes(sz) - 1);
        nacc = (last[31:2] == a[31:2]) ? 1 : 2;
        acc_log.delete();
        @(negedge clock);
        wait_cfg   = waitc;
        stall_left = waitc;
        req_valid  = 1'b1;
        req_addr   = a;
        req_size   = sz;
        req_signed = sgn;
        out_ready  = (bp == 0);
        @(posedge clock);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 1) req_valid = 1'b0;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        check("latency", 32'(cyc), 32'(lit_cycles));
        if (bp > 0) begin
            repeat (bp) @(negedge clock);
            out_ready = 1'b1;
        end
        @(negedge clock);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("req_ready_after_hs", 32'(req_ready), 32'd1);
        check("access_count", 32'(acc_log.size()), 32'(nacc));
        if (acc_log.size() >= 1) check("first_addr", 32'(acc_log[0]), 32'(a[31:2]));
        if (acc_log.size() >= 2) check("second_addr", 32'(acc_log[1]), 32'(last[31:2]));
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        out_ready  = 1'b0;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_se", 32'(out_se_ctrl), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        mem_words[30'h400] = 32'h1122_8044;
        do_load(32'h1001, 2'd0, 1'b1, 0, 0, 32'h0000_0080, 3'd2, 2);

        mem_words[30'h800] = 32'hBEEF_1234;
        do_load(32'h2002, 2'd1, 1'b0, 0, 0, 32'h0000_BEEF, 3'd3, 2);

        mem_words[30'h800] = 32'hAB00_0000;
        mem_words[30'h801] = 32'h0000_00CD;
        do_load(32'h2003, 2'd1, 1'b1, 0, 0, 32'h0000_CDAB, 3'd1, 3);

        mem_words[30'h3FFF_FFFF] = 32'h3344_0000;
        mem_words[30'h0]         = 32'h0000_1122;
        do_load(32'hFFFF_FFFE, 2'd2, 1'b1, 0, 0, 32'h1122_3344, 3'd0, 3);

        mem_words[30'hC00] = 32'hDEAD_BEEF;
        do_load(32'h3000, 2'd2, 1'b1, 3, 2, 32'hDEAD_BEEF, 3'd0, 5);

        mem_words[30'h401] = 32'h5566_7788;
        mem_words[30'h402] = 32'h99AA_BBCC;
        do_load(32'h1005, 2'd3, 1'b0, 0, 0, 32'hCC55_6677, 3'd0, 3);
        do_load(32'h1007, 2'd0, 1'b0, 0, 1, 32'h0000_0055, 3'd4, 2);
        do_load(32'h1004, 2'd1, 1'b1, 1, 0, 32'h0000_7788, 3'd1, 3);

        // Reset while the second access of a split load is stalled.
        acc_log.delete();
        @(negedge clock);
        wait_cfg   = 4;
        stall_left = 4;
        req_valid  = 1'b1;
        req_addr   = 32'h2003;
        req_size   = 2'd1;
        req_signed = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (acc_log.size() >= 1) break;
        end
        check("reached_second", 32'(acc_log.size()), 32'd1);
        check("second_mem_req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_mem_req_drop", 32'(mem_req), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_mem_req", 32'(mem_req), 32'd0);

        mem_words[30'h0] = 32'hCAFE_F00D;
        do_load(32'h0000_0000, 2'd2, 1'b0, 0, 0, 32'hCAFE_F00D, 3'd0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
